// File: rtl/seg7_pair_decoder_if.sv
// Segment bus in, decoded result out over a valid/ready handshake.
// The decoder drives the result side; the consumer drives the segment bus and ready.
interface seg7_pair_decoder_if;
    logic [13:0] seg_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  value;
    logic [3:0]  mag;
    logic        neg;
    logic        err;
    logic        overrun;

    modport master (
        input  seg_in,
        input  out_ready,
        output out_valid,
        output value,
        output mag,
        output neg,
        output err,
        output overrun
    );

    modport slave (
        output seg_in,
        output out_ready,
        input  out_valid,
        input  value,
        input  mag,
        input  neg,
        input  err,
        input  overrun
    );
endinterface

// File: rtl/seg7_pair_decoder.sv
// Recovers the number shown on a two-digit active-low seven-segment bus.
// Reports once per distinct stable pattern over a valid/ready handshake.
module seg7_pair_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    seg7_pair_decoder_if.master bus
);

    localparam logic [7:0]  StableCnt = 8'(STABLE_CYCLES);
    localparam logic [13:0] AllOff    = 14'h3FFF;
    localparam logic [6:0]  TensBlank = 7'b1111111;
    localparam logic [6:0]  TensOne   = 7'b1111001;
    localparam logic [6:0]  TensMinus = 7'b0111111;

    typedef enum logic {StIdle, StReport} state_t;

    state_t      state_q, state_d;
    logic [13:0] seg_q;
    logic [7:0]  cnt_q;
    logic        stable;
    logic [13:0] last_pat_q, last_pat_d;
    logic        have_last_q, have_last_d;
    logic [3:0]  value_q, value_d;
    logic [3:0]  mag_q, mag_d;
    logic        neg_q, neg_d;
    logic        err_q, err_d;
    logic        overrun_q, overrun_d;

    logic        ones_ok;
    logic [3:0]  ones_d;
    logic [3:0]  dec_value;
    logic [3:0]  dec_mag;
    logic        dec_neg;
    logic        dec_err;

    assign stable = (cnt_q == StableCnt);

    always_comb begin
        ones_ok = 1'b1;
        ones_d  = 4'd0;
        case (seg_q[6:0])
            7'b1000000: ones_d = 4'd0;
            7'b1111001: ones_d = 4'd1;
            7'b0100100: ones_d = 4'd2;
            7'b0110000: ones_d = 4'd3;
            7'b0011001: ones_d = 4'd4;
            7'b0010010: ones_d = 4'd5;
            7'b0000010: ones_d = 4'd6;
            7'b1111000: ones_d = 4'd7;
            7'b0000000: ones_d = 4'd8;
            7'b0011000: ones_d = 4'd9;
            default:    ones_ok = 1'b0;
        endcase

        dec_value = 4'd0;
        dec_mag   = 4'd0;
        dec_neg   = 1'b0;
        dec_err   = 1'b0;
        if (ones_ok && seg_q[13:7] == TensBlank) begin
            dec_value = ones_d;
            dec_mag   = ones_d;
        end else if (ones_ok && seg_q[13:7] == TensOne && ones_d <= 4'd5) begin
            dec_value = ones_d + 4'd10;
            dec_mag   = ones_d + 4'd10;
        end else if (ones_ok && seg_q[13:7] == TensMinus && ones_d >= 4'd1 && ones_d <= 4'd7) begin
            dec_value = 4'd0 - ones_d;
            dec_mag   = ones_d;
            dec_neg   = 1'b1;
        end else begin
            dec_err = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_pat_d  = last_pat_q;
        have_last_d = have_last_q;
        value_d     = value_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        err_d       = err_q;
        overrun_d   = overrun_q;
        unique case (state_q)
            StIdle: begin
                // A settled blank display is remembered but never reported.
                if (stable && (!have_last_q || seg_q != last_pat_q)) begin
                    last_pat_d  = seg_q;
                    have_last_d = 1'b1;
                    if (seg_q != AllOff) begin
                        value_d = dec_value;
                        mag_d   = dec_mag;
                        neg_d   = dec_neg;
                        err_d   = dec_err;
                        state_d = StReport;
                    end
                end
            end
            StReport: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
                if (stable && seg_q != last_pat_q && seg_q != AllOff) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            seg_q       <= AllOff;
            cnt_q       <= 8'd0;
            last_pat_q  <= AllOff;
            have_last_q <= 1'b0;
            value_q     <= 4'd0;
            mag_q       <= 4'd0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= bus.seg_in;
            if (bus.seg_in != seg_q) begin
                cnt_q <= 8'd0;
            end else if (cnt_q < StableCnt) begin
                cnt_q <= cnt_q + 8'd1;
            end
            last_pat_q  <= last_pat_d;
            have_last_q <= have_last_d;
            value_q     <= value_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = (state_q == StReport);
    assign bus.value     = value_q;
    assign bus.mag       = mag_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed bench for seg7_pair_decoder with hand-computed expected results.
module tb_seg7_pair_decoder;

    localparam logic [13:0] SegOff   = 14'h3FFF;
    localparam logic [13:0] SegTwo   = 14'b1111111_0100100;
    localparam logic [13:0] SegNeg3  = 14'b0111111_0110000;
    localparam logic [13:0] SegFive  = 14'b1111111_0010010;
    localparam logic [13:0] SegFift  = 14'b1111001_0010010;
    localparam logic [13:0] SegSixt  = 14'b1111001_0000010;
    localparam logic [13:0] SegFour  = 14'b1111111_0011001;
    localparam logic [13:0] SegNeg1  = 14'b0111111_1111001;
    localparam logic [13:0] SegSeven = 14'b1111111_1111000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    seg7_pair_decoder_if bus ();

    seg7_pair_decoder #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ticks until out_valid is seen; n is the number of edges taken (40 means timed out).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.out_valid && n < 40);
    endtask

    initial begin
        int n;
        int pulses;
        logic [3:0] seen_value;
        logic [3:0] seen_mag;

        bus.seg_in    = SegOff;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1: blank display never reports
        check("t1_valid_rst", 16'(bus.out_valid), 16'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        check("t1_no_report", 16'(pulses), 16'd0);
        check("t1_outs", {8'd0, bus.value, bus.mag}, 16'd0);
        check("t1_flags", {13'd0, bus.neg, bus.err, bus.overrun}, 16'd0);

        // 2: "2" with ready high, report on edge 6 as a single pulse
        bus.out_ready = 1'b1;
        bus.seg_in    = SegTwo;
        wait_valid(n);
        check("t2_latency", 16'(n), 16'd6);
        check("t2_value", 16'(bus.value), 16'd2);
        check("t2_mag", 16'(bus.mag), 16'd2);
        check("t2_neg_err", {14'd0, bus.neg, bus.err}, 16'd0);
        tick();
        check("t2_pulse_end", 16'(bus.out_valid), 16'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        check("t2_no_repeat", 16'(pulses), 16'd0);

        // 3: "-3" held pending with ready low
        bus.out_ready = 1'b0;
        bus.seg_in    = SegNeg3;
        wait_valid(n);
        check("t3_latency", 16'(n), 16'd6);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!bus.out_valid || bus.value != 4'b1101 || bus.mag != 4'd3 || !bus.neg) pulses++;
        end
        check("t3_hold_bad", 16'(pulses), 16'd0);
        check("t3_value", 16'(bus.value), 16'hD);
        bus.out_ready = 1'b1;
        tick();
        check("t3_accept", 16'(bus.out_valid), 16'd0);

        // 4: alternating "5"/"15" every 3 cycles, then hold "15"
        pulses     = 0;
        seen_value = 4'd0;
        seen_mag   = 4'd0;
        for (int i = 0; i < 60; i++) begin
            if (i < 30) bus.seg_in = ((i / 3) % 2 == 0) ? SegFive : SegFift;
            else        bus.seg_in = SegFift;
            tick();
            if (bus.out_valid) begin
                pulses++;
                seen_value = bus.value;
                seen_mag   = bus.mag;
            end
        end
        check("t4_one_report", 16'(pulses), 16'd1);
        check("t4_value", 16'(seen_value), 16'd15);
        check("t4_mag", 16'(seen_mag), 16'd15);

        // 5: "16" is not a legal display
        bus.seg_in = SegSixt;
        wait_valid(n);
        check("t5_latency", 16'(n), 16'd6);
        check("t5_err", 16'(bus.err), 16'd1);
        check("t5_outs", {7'd0, bus.neg, bus.value, bus.mag}, 16'd0);
        tick();

        // 6: overrun while "4" is pending
        bus.out_ready = 1'b0;
        bus.seg_in    = SegFour;
        wait_valid(n);
        check("t6_four_lat", 16'(n), 16'd6);
        check("t6_four", 16'(bus.value), 16'd4);
        bus.seg_in = SegNeg1;
        for (int i = 0; i < 8; i++) tick();
        check("t6_overrun", 16'(bus.overrun), 16'd1);
        check("t6_frozen", {bus.value, bus.mag, 7'd0, bus.out_valid}, 16'h4401);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t6_accept", 16'(bus.out_valid), 16'd0);
        wait_valid(n);
        check("t6_next_seen", 16'(n < 40), 16'd1);
        check("t6_next_value", 16'(bus.value), 16'hF);
        check("t6_next_sign", {8'd0, bus.mag, 3'd0, bus.neg}, 16'h0011);
        check("t6_sticky", 16'(bus.overrun), 16'd1);
        bus.out_ready = 1'b1;
        tick();

        // 7: reset mid-settle on "7"
        bus.seg_in = SegSeven;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_rst_outs", {7'd0, bus.out_valid, bus.value, bus.mag}, 16'd0);
        check("t7_rst_flags", {13'd0, bus.neg, bus.err, bus.overrun}, 16'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        check("t7_no_early", 16'(pulses), 16'd0);
        tick();
        check("t7_valid_edge10", 16'(bus.out_valid), 16'd1);
        check("t7_value", 16'(bus.value), 16'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
